// File: rtl/fx2_if_pkg.sv
// Shared types and constants for the FX2 slave-FIFO register bridge.
package fx2_if_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR    = 3'd1,
        WDATA  = 3'd2,
        RTURN  = 3'd3,
        RDATA  = 3'd4,
        PKTEND = 3'd5
    } state_t;

    localparam logic [7:0]  SYNC     = 8'hA5;
    localparam logic [7:0]  CMD_WR   = 8'h01;
    localparam logic [7:0]  CMD_RD   = 8'h02;
    localparam logic [1:0]  EP_OUT   = 2'b00;
    localparam logic [1:0]  EP_IN    = 2'b10;
    localparam logic [15:0] BAD_TERM = 16'hDEAD;

    // A short packet must be committed unless the transfer filled whole 512-byte packets.
    function automatic logic needs_pktend(input logic [15:0] nwords);
        return nwords[7:0] != 8'd0;
    endfunction

endpackage

// File: rtl/fx2_regfile.sv
// Terminal-0 register file: NREGS x 16 bits, one synchronous write port, one combinational read port.
module fx2_regfile #(
    parameter int NREGS = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = regs[raddr];

endmodule

// File: rtl/fpga_fx2_if.sv
// FX2 slave-FIFO command bridge: parses EP2 headers, writes/reads a register file, returns data on EP6.
// Optional FPGA_CHECKSUM_EN appends a 16-bit wrapping sum word to every read.
module fpga_fx2_if
    import fx2_if_pkg::*;
#(
    parameter int NREGS = 16  // power of 2, 2..256
) (
    input  logic        fx2_ifclk,
    input  logic        rst,
    input  logic        fx2_clkout,
    input  logic        fx2_hics_b,
    input  logic [2:0]  fx2_flags,
    output logic [1:0]  fx2_fifo_addr,
    output logic        fx2_sloe_b,
    output logic        fx2_slrd_b,
    output logic        fx2_slwr_b,
    output logic        fx2_pktend_b,
    inout  wire  [15:0] fx2_fd,
    output state_t      fsm_state
);

    localparam int AW = $clog2(NREGS);

    state_t        state, next_state;
    logic [1:0]    hdr_idx;
    logic          is_rd;
    logic [15:0]   term;
    logic [AW-1:0] addr;
    logic [15:0]   len_left;
    logic [15:0]   len_total;
    logic          pkt_needed;
    logic          fd_oe;
    logic [15:0]   rf_rdata, data_word, out_word;
    logic          rd_fire, wr_fire, pk_fire, rf_we, cmd_ok;

    logic unused_inputs;
    assign unused_inputs = ^{fx2_clkout, fx2_flags[2]};

    // Handshake: each strobe is a registered one-cycle "valid" issued only when the matching
    // flag ("ready") was seen high; a word transfers on the edge that ends the strobe cycle,
    // provided hics_b is low. A strobe is never re-issued on its own transfer edge, so the
    // flag always has a full cycle to reflect the previous transfer.
    assign rd_fire = !fx2_slrd_b   && !fx2_hics_b && (state == HDR || state == WDATA);
    assign wr_fire = !fx2_slwr_b   && !fx2_hics_b && (state == RDATA);
    assign pk_fire = !fx2_pktend_b && !fx2_hics_b && (state == PKTEND);

    assign cmd_ok = (fx2_fd[15:8] == SYNC) &&
                    ((fx2_fd[7:0] == CMD_WR) || (fx2_fd[7:0] == CMD_RD));
    assign rf_we  = (state == WDATA) && rd_fire && (term == 16'd0);
    assign data_word = (term != 16'd0) ? BAD_TERM : rf_rdata;

`ifdef FPGA_CHECKSUM_EN
    logic [15:0] csum;

    always_ff @(posedge fx2_ifclk or posedge rst) begin
        if (rst)                  csum <= '0;
        else if (state == HDR)    csum <= '0;
        else if (wr_fire)         csum <= csum + out_word;
    end

    assign len_total = fx2_fd + 16'd1;

    always_comb begin
        out_word = data_word;
        if (len_left == 16'd1) out_word = csum;
    end
`else
    assign len_total = fx2_fd;
    assign out_word  = data_word;
`endif

    fx2_regfile #(.NREGS(NREGS), .AW(AW)) u_regfile (
        .clk   (fx2_ifclk),
        .rst   (rst),
        .we    (rf_we),
        .waddr (addr),
        .wdata (fx2_fd),
        .raddr (addr),
        .rdata (rf_rdata)
    );

    always_ff @(posedge fx2_ifclk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (!fx2_hics_b && fx2_flags[0]) next_state = HDR;
            HDR: begin
                if (rd_fire && hdr_idx == 2'd3) begin
                    if (fx2_fd == 16'd0) next_state = IDLE;
                    else if (is_rd)      next_state = RTURN;
                    else                 next_state = WDATA;
                end
            end
            WDATA:  if (rd_fire && len_left == 16'd1) next_state = IDLE;
            RTURN:  if (!fx2_hics_b) next_state = RDATA;
            RDATA:  if (wr_fire && len_left == 16'd1) next_state = PKTEND;
            PKTEND: if (!fx2_hics_b && (pk_fire || !pkt_needed)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Header parser and transfer bookkeeping; a bad CMD word is dropped and parsing restarts.
    always_ff @(posedge fx2_ifclk or posedge rst) begin
        if (rst) begin
            hdr_idx    <= '0;
            is_rd      <= 1'b0;
            term       <= '0;
            addr       <= '0;
            len_left   <= '0;
            pkt_needed <= 1'b0;
        end else if (state == HDR && rd_fire) begin
            case (hdr_idx)
                2'd0: if (cmd_ok) begin
                    is_rd   <= (fx2_fd[7:0] == CMD_RD);
                    hdr_idx <= 2'd1;
                end
                2'd1: begin
                    term    <= fx2_fd;
                    hdr_idx <= 2'd2;
                end
                2'd2: begin
                    addr    <= fx2_fd[AW-1:0];
                    hdr_idx <= 2'd3;
                end
                default: begin
                    len_left   <= len_total;
                    pkt_needed <= needs_pktend(len_total);
                    hdr_idx    <= 2'd0;
                end
            endcase
        end else if ((state == WDATA && rd_fire) || wr_fire) begin
            addr     <= addr + AW'(1);
            len_left <= len_left - 16'd1;
        end
    end

    // Bus-direction outputs follow the next state so the bus turnaround (RTURN) is a clean idle cycle.
    always_ff @(posedge fx2_ifclk or posedge rst) begin
        if (rst) begin
            fx2_sloe_b    <= 1'b1;
            fx2_slrd_b    <= 1'b1;
            fx2_slwr_b    <= 1'b1;
            fx2_pktend_b  <= 1'b1;
            fx2_fifo_addr <= EP_OUT;
            fd_oe         <= 1'b0;
        end else begin
            fx2_sloe_b    <= !(next_state == HDR || next_state == WDATA);
            fx2_fifo_addr <= (next_state == RTURN || next_state == RDATA || next_state == PKTEND)
                             ? EP_IN : EP_OUT;
            fd_oe         <= (next_state == RDATA);
            fx2_slrd_b    <= !(!fx2_hics_b && fx2_slrd_b && fx2_flags[0] &&
                               (next_state == HDR || next_state == WDATA));
            fx2_slwr_b    <= !(!fx2_hics_b && fx2_slwr_b && fx2_flags[1] && state == RDATA);
            fx2_pktend_b  <= !(!fx2_hics_b && fx2_pktend_b && pkt_needed && state == PKTEND);
        end
    end

    assign fx2_fd    = fd_oe ? out_word : 16'hzzzz;
    assign fsm_state = state;

endmodule

// File: tb/tb_fpga_fx2_if.sv
// Directed bench for fpga_fx2_if: models the FX2 EP2/EP6 FIFOs and checks register traffic and strobes.
module tb_fpga_fx2_if;
    import fx2_if_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clkout = 1'b0;
    logic hics_b = 1'b0;
    logic ep6_ok = 1'b1;
    logic ep2_ne = 1'b0;
    logic [15:0] ep2_head = 16'h0000;

    tri1  [15:0] fd;
    logic [2:0]  flags;
    logic [1:0]  fifo_addr;
    logic        sloe_b, slrd_b, slwr_b, pktend_b;
    state_t      fsm_state;

    logic [15:0] ep2_q[$];
    logic [15:0] ep6_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] model[16];

    int n_checks = 0;
    int n_pass = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;
    int pk_pulses = 0;
    int viol = 0;
    logic prev_sloe_low = 1'b0;

    assign flags = {1'b0, ep6_ok, ep2_ne};
    assign fd = (!sloe_b && fifo_addr == 2'b00) ? ep2_head : 16'hzzzz;

    fpga_fx2_if #(.NREGS(16)) dut (
        .fx2_ifclk     (clk),
        .rst           (rst),
        .fx2_clkout    (clkout),
        .fx2_hics_b    (hics_b),
        .fx2_flags     (flags),
        .fx2_fifo_addr (fifo_addr),
        .fx2_sloe_b    (sloe_b),
        .fx2_slrd_b    (slrd_b),
        .fx2_slwr_b    (slwr_b),
        .fx2_pktend_b  (pktend_b),
        .fx2_fd        (fd),
        .fsm_state     (fsm_state)
    );

    // ---- clock / watchdog ----
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // ---- FX2 FIFO model: EP2 pops and EP6 captures on the edge that ends a strobe cycle ----
    always @(posedge clk) begin
        logic do_pop;
        do_pop = !rst && !slrd_b && !hics_b && !sloe_b;
        if (!slrd_b)   rd_pulses++;
        if (!slwr_b)   wr_pulses++;
        if (!pktend_b) pk_pulses++;
        if (!rst && !slwr_b && !hics_b) ep6_q.push_back(fd);
        #1;
        if (do_pop && ep2_q.size() != 0) void'(ep2_q.pop_front());
        ep2_ne   = (ep2_q.size() != 0);
        ep2_head = ep2_ne ? ep2_q[0] : 16'h0000;
    end

    // ---- bus protocol monitor ----
    always @(negedge clk) begin
        if (!slrd_b && !slwr_b) viol++;
        if (!slwr_b && prev_sloe_low) viol++;
        if (!sloe_b && fd !== ep2_head) viol++;
        prev_sloe_low = !sloe_b;
    end

    // ---- scoreboard helpers ----
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cmd(input logic [15:0] c, input logic [15:0] t,
                       input logic [15:0] a, input logic [15:0] l);
        ep2_q.push_back(c);
        ep2_q.push_back(t);
        ep2_q.push_back(a);
        ep2_q.push_back(l);
    endtask

    task automatic wait_done(input string tag);
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 3 && n < 3000) begin
            @(negedge clk);
            n++;
            if (ep2_q.size() == 0 && !ep2_ne && sloe_b && fifo_addr == 2'b00) quiet++;
            else quiet = 0;
        end
        check({tag, "_done"}, 32'(quiet >= 3), 32'd1);
    endtask

    task automatic expect_ep6(input string tag);
        logic [15:0] e;
        logic [15:0] g;
        check({tag, "_count"}, 32'(ep6_q.size()), 32'(exp_q.size()));
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = 16'hxxxx;
            if (ep6_q.size() != 0) g = ep6_q.pop_front();
            check({tag, "_data"}, 32'(g), 32'(e));
        end
        ep6_q.delete();
    endtask

    task automatic do_read(input string tag, input logic [15:0] t, input logic [15:0] a,
                           input logic [15:0] l, input int exp_pk);
        int pk0;
        pk0 = pk_pulses;
        cmd(16'hA502, t, a, l);
        wait_done(tag);
        expect_ep6(tag);
        check({tag, "_pktend"}, 32'(pk_pulses - pk0), 32'(exp_pk));
    endtask

    // ---- directed sequence ----
    initial begin
        int r0;
        int w0;
        int n;
        int cnt;
        logic [15:0] fd_ref;

        for (int i = 0; i < 16; i++) model[i] = 16'h0000;

        repeat (3) @(negedge clk);
        check("rst_sloe", 32'(sloe_b), 32'd1);
        check("rst_slrd", 32'(slrd_b), 32'd1);
        check("rst_slwr", 32'(slwr_b), 32'd1);
        check("rst_pktend", 32'(pktend_b), 32'd1);
        check("rst_addr", 32'(fifo_addr), 32'd0);
        check("rst_fd", 32'(fd), 32'hFFFF);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
        rst = 1'b0;

        // write 1111,2222 to reg3/reg4
        r0 = rd_pulses;
        w0 = wr_pulses;
        cmd(16'hA501, 16'h0000, 16'h0003, 16'h0002);
        ep2_q.push_back(16'h1111);
        ep2_q.push_back(16'h2222);
        wait_done("wr3");
        check("wr3_slrd", 32'(rd_pulses - r0), 32'd6);
        check("wr3_slwr", 32'(wr_pulses - w0), 32'd0);
        model[3] = 16'h1111;
        model[4] = 16'h2222;

        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h2222);
        do_read("rd3", 16'h0000, 16'h0003, 16'h0002, 1);

        // write across the top of the register file
        cmd(16'hA501, 16'h0000, 16'h000F, 16'h0003);
        ep2_q.push_back(16'hAAA1);
        ep2_q.push_back(16'hAAA2);
        ep2_q.push_back(16'hAAA3);
        wait_done("wr15");
        model[15] = 16'hAAA1;
        model[0]  = 16'hAAA2;
        model[1]  = 16'hAAA3;

        exp_q.push_back(16'hAAA2);
        exp_q.push_back(16'hAAA3);
        do_read("rd0", 16'h0000, 16'h0000, 16'h0002, 1);

        // read with EP6 full for 5 cycles after the first word
        w0 = pk_pulses;
        cmd(16'hA502, 16'h0000, 16'h000F, 16'h0003);
        n = 0;
        while (ep6_q.size() == 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("stall_first", 32'(ep6_q.size()), 32'd1);
        ep6_ok = 1'b0;
        fd_ref = fd;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (!slwr_b || fd !== fd_ref) cnt++;
        end
        check("stall_hold_fd", 32'(fd_ref), 32'hAAA2);
        check("stall_quiet", 32'(cnt), 32'd0);
        ep6_ok = 1'b1;
        wait_done("stall");
        exp_q.push_back(16'hAAA1);
        exp_q.push_back(16'hAAA2);
        exp_q.push_back(16'hAAA3);
        expect_ep6("stall");
        check("stall_pktend", 32'(pk_pulses - w0), 32'd1);

        // nonzero terminal: read returns DEAD, write is swallowed
        exp_q.push_back(16'hDEAD);
        do_read("term5", 16'h0005, 16'h0003, 16'h0001, 1);
        cmd(16'hA501, 16'h0007, 16'h0003, 16'h0001);
        ep2_q.push_back(16'hBEEF);
        wait_done("wrterm");

        // stray word ahead of a header is dropped
        ep2_q.push_back(16'h1234);
        exp_q.push_back(16'h1111);
        do_read("badhdr", 16'h0000, 16'h0003, 16'h0001, 1);

        // zero-length read: no data, no packet end
        do_read("len0", 16'h0000, 16'h0002, 16'h0000, 0);

        // host deselect in the middle of a write header
        cmd(16'hA501, 16'h0000, 16'h0008, 16'h0002);
        ep2_q.push_back(16'h5555);
        ep2_q.push_back(16'h6666);
        repeat (5) @(negedge clk);
        hics_b = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (!slrd_b || !slwr_b || !pktend_b) cnt++;
        end
        hics_b = 1'b0;
        wait_done("hics");
        check("hics_strobes", 32'(cnt), 32'd0);
        model[8] = 16'h5555;
        model[9] = 16'h6666;
        exp_q.push_back(16'h5555);
        exp_q.push_back(16'h6666);
        do_read("rd8", 16'h0000, 16'h0008, 16'h0002, 1);

        // 256 words fill whole packets, so no packet end
        for (int i = 0; i < 256; i++) exp_q.push_back(model[i % 16]);
        do_read("rd256", 16'h0000, 16'h0000, 16'h0100, 0);

        // reset in the middle of a write data phase
        r0 = rd_pulses;
        cmd(16'hA501, 16'h0000, 16'h0005, 16'h0004);
        ep2_q.push_back(16'h0001);
        ep2_q.push_back(16'h0002);
        ep2_q.push_back(16'h0003);
        ep2_q.push_back(16'h0004);
        n = 0;
        while (rd_pulses - r0 < 6 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rstmid_reach", 32'(rd_pulses - r0 >= 6), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_sloe", 32'(sloe_b), 32'd1);
        check("rstmid_slrd", 32'(slrd_b), 32'd1);
        check("rstmid_slwr", 32'(slwr_b), 32'd1);
        check("rstmid_pktend", 32'(pktend_b), 32'd1);
        check("rstmid_addr", 32'(fifo_addr), 32'd0);
        check("rstmid_state", 32'(fsm_state), 32'(IDLE));
        repeat (2) @(negedge clk);
        ep2_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        exp_q.push_back(16'h0000);
        do_read("clr3", 16'h0000, 16'h0003, 16'h0001, 1);
        exp_q.push_back(16'h0000);
        do_read("clr5", 16'h0000, 16'h0005, 16'h0001, 1);

        check("protocol_viol", 32'(viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
